// File: rtl/lag_pl_out_scheduler_if.sv
// Request/grant bundle between the requesters and the PL output scheduler.
// The master drives requests and PL credit status; the slave (scheduler) returns grants.
interface lag_pl_out_scheduler_if #(
    parameter int num_reqs = 4,
    parameter int num_pls  = 4
);
    localparam int pl_bits  = (num_pls  > 1) ? $clog2(num_pls)  : 1;
    localparam int req_bits = (num_reqs > 1) ? $clog2(num_reqs) : 1;

    logic [num_reqs-1:0]          req_valid;
    logic [num_reqs*pl_bits-1:0]  req_pl;
    logic [num_reqs-1:0]          req_head;
    logic [num_reqs-1:0]          req_tail;
    logic [num_pls-1:0]           pl_status;
    logic [num_reqs-1:0]          gnt;
    logic [num_pls-1:0]           flits_valid;
    logic [num_pls*req_bits-1:0]  pl_owner;
    logic [num_pls-1:0]           pl_locked;
    logic                         err_proto;

    modport master (
        output req_valid, req_pl, req_head, req_tail, pl_status,
        input  gnt, flits_valid, pl_owner, pl_locked, err_proto
    );

    modport slave (
        input  req_valid, req_pl, req_head, req_tail, pl_status,
        output gnt, flits_valid, pl_owner, pl_locked, err_proto
    );
endinterface

// File: rtl/lag_pl_out_scheduler.sv
// Credit-aware round-robin scheduler of an output port's physical lanes.
// Grants are combinational; each PL holds its winner from head flit to tail flit.
module lag_pl_out_scheduler #(
    parameter int num_reqs = 4,
    parameter int num_pls  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lag_pl_out_scheduler_if.slave  bus
);
    localparam int pl_bits  = (num_pls  > 1) ? $clog2(num_pls)  : 1;
    localparam int req_bits = (num_reqs > 1) ? $clog2(num_reqs) : 1;

    logic [1:0]                          rst_sync_reg;
    logic                                run;
    logic [num_pls-1:0]                  lock_reg, lock_next;
    logic [num_pls-1:0][req_bits-1:0]    owner_reg, owner_next;
    logic [num_pls-1:0][req_bits-1:0]    ptr_reg, ptr_next;
    logic [num_pls-1:0][req_bits-1:0]    win_idx;
    logic [num_pls-1:0]                  grant_pl, win_tail;
    logic [num_reqs-1:0][pl_bits-1:0]    req_pl_arr;
    logic [num_reqs-1:0]                 gnt_c;
    logic                                err_reg, err_next, err_hit;

    assign req_pl_arr = bus.req_pl;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign run = rst_sync_reg[1];

    // Per-PL arbitration: locked PLs only follow their owner, idle PLs search round-robin.
    always_comb begin
        int idx;
        idx      = 0;
        grant_pl = '0;
        win_idx  = owner_reg;
        win_tail = '0;
        err_hit  = 1'b0;
        for (int p = 0; p < num_pls; p++) begin
            if (lock_reg[p]) begin
                for (int r = 0; r < num_reqs; r++) begin
                    if (bus.req_valid[r] && int'(req_pl_arr[r]) == p &&
                        req_bits'(r) == owner_reg[p]) begin
                        if (bus.req_head[r]) begin
                            err_hit = 1'b1;
                        end else if (!bus.pl_status[p]) begin
                            grant_pl[p] = 1'b1;
                            win_tail[p] = bus.req_tail[r];
                        end
                    end
                end
            end else begin
                for (int k = 1; k <= num_reqs; k++) begin
                    idx = (int'(ptr_reg[p]) + k) % num_reqs;
                    if (bus.req_valid[idx] && int'(req_pl_arr[idx]) == p) begin
                        if (!bus.req_head[idx]) begin
                            err_hit = 1'b1;
                        end else if (!grant_pl[p] && !bus.pl_status[p]) begin
                            grant_pl[p] = 1'b1;
                            win_idx[p]  = req_bits'(idx);
                            win_tail[p] = bus.req_tail[idx];
                        end
                    end
                end
            end
        end
        if (!run) begin
            grant_pl = '0;
            win_idx  = owner_reg;
            err_hit  = 1'b0;
        end
    end

    always_comb begin
        gnt_c = '0;
        for (int p = 0; p < num_pls; p++) begin
            for (int r = 0; r < num_reqs; r++) begin
                if (grant_pl[p] && win_idx[p] == req_bits'(r)) begin
                    gnt_c[r] = 1'b1;
                end
            end
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.flits_valid = grant_pl;
    assign bus.pl_owner    = win_idx;
    assign bus.pl_locked   = lock_reg;
    assign bus.err_proto   = err_reg;

    // Single-flit packets only move the pointer; multi-flit heads also take ownership.
    always_comb begin
        lock_next  = lock_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        for (int p = 0; p < num_pls; p++) begin
            if (grant_pl[p]) begin
                if (!lock_reg[p]) begin
                    ptr_next[p] = win_idx[p];
                    if (!win_tail[p]) begin
                        lock_next[p]  = 1'b1;
                        owner_next[p] = win_idx[p];
                    end
                end else if (win_tail[p]) begin
                    lock_next[p] = 1'b0;
                end
            end
        end
        err_next = err_reg | err_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_reg  <= '0;
            owner_reg <= '0;
            ptr_reg   <= {num_pls{req_bits'(num_reqs - 1)}};
            err_reg   <= 1'b0;
        end else begin
            lock_reg  <= lock_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            err_reg   <= err_next;
        end
    end
endmodule

// File: tb/tb_lag_pl_out_scheduler.sv
// Directed, table-driven bench for lag_pl_out_scheduler (4 requesters, 4 PLs).
// Vectors run back to back from reset; state carries from one record to the next.
module tb_lag_pl_out_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lag_pl_out_scheduler_if #(.num_reqs(4), .num_pls(4)) bus ();
    lag_pl_out_scheduler #(.num_reqs(4), .num_pls(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] rv;
        logic [7:0] pl;
        logic [3:0] hd;
        logic [3:0] tl;
        logic [3:0] st;
        logic [3:0] gnt;
        logic [3:0] fv;
        logic [3:0] lk;
        logic [7:0] own;
        logic       err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    int n_checks = 0;
    int n_fails  = 0;

    function automatic vec_t mk(input logic [3:0] rv, input logic [7:0] pl,
                                input logic [3:0] hd, input logic [3:0] tl,
                                input logic [3:0] st, input logic [3:0] gnt,
                                input logic [3:0] fv, input logic [3:0] lk,
                                input logic [7:0] own, input logic err);
        vec_t v;
        v.rv = rv; v.pl = pl; v.hd = hd; v.tl = tl; v.st = st;
        v.gnt = gnt; v.fv = fv; v.lk = lk; v.own = own; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic [7:0] pl,
                         input logic [3:0] hd, input logic [3:0] tl, input logic [3:0] st);
        bus.req_valid = rv;
        bus.req_pl    = pl;
        bus.req_head  = hd;
        bus.req_tail  = tl;
        bus.pl_status = st;
    endtask

    initial begin
        // rv, req_pl{r3..r0}, head, tail, pl_status | gnt, flits_valid, pl_locked, pl_owner{p3..p0}, err
        vecs[0]  = mk(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 8'h00, 1'b0);
        vecs[1]  = mk(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 8'h01, 1'b0);
        vecs[2]  = mk(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 8'h00, 1'b0);
        vecs[3]  = mk(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 8'h01, 1'b0);
        vecs[4]  = mk(4'b0011, 8'h0A, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 8'h00, 1'b0);
        vecs[5]  = mk(4'b0011, 8'h0A, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 8'h00, 1'b0);
        vecs[6]  = mk(4'b0011, 8'h0A, 4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 8'h00, 1'b0);
        vecs[7]  = mk(4'b0010, 8'h0A, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 8'h10, 1'b0);
        vecs[8]  = mk(4'b0101, 8'h30, 4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b1001, 4'b0000, 8'h80, 1'b0);
        vecs[9]  = mk(4'b1000, 8'h40, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000, 8'h0C, 1'b0);
        for (int i = 10; i < 14; i++)
            vecs[i] = mk(4'b1100, 8'h50, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 8'h0C, 1'b0);
        vecs[14] = mk(4'b1100, 8'h50, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0010, 4'b0010, 8'h0C, 1'b0);
        vecs[15] = mk(4'b1100, 8'h50, 4'b0100, 4'b1100, 4'b0000, 4'b1000, 4'b0010, 4'b0010, 8'h0C, 1'b0);
        vecs[16] = mk(4'b0100, 8'h50, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 8'h08, 1'b0);
        vecs[17] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h0C, 1'b0);
        vecs[18] = mk(4'b0010, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h0C, 1'b0);
        vecs[19] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h0C, 1'b1);
        vecs[20] = mk(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 8'h0D, 1'b1);

        // Reset state, with a request present to show grants are suppressed.
        drive(4'b0001, 8'h00, 4'b0001, 4'b0001, 4'b0000);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst.gnt", 32'(bus.gnt), 32'h0);
        check("rst.fv", 32'(bus.flits_valid), 32'h0);
        check("rst.locked", 32'(bus.pl_locked), 32'h0);
        check("rst.owner", 32'(bus.pl_owner), 32'h0);
        check("rst.err", 32'(bus.err_proto), 32'h0);
        drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1 drive(vecs[i].rv, vecs[i].pl, vecs[i].hd, vecs[i].tl, vecs[i].st);
            @(negedge clk);
            $display("vec %0d rv=%b st=%b gnt=%b fv=%b locked=%b owner=%h err=%b", i,
                     vecs[i].rv, vecs[i].st, bus.gnt, bus.flits_valid, bus.pl_locked,
                     bus.pl_owner, bus.err_proto);
            check($sformatf("v%0d.gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d.fv", i), 32'(bus.flits_valid), 32'(vecs[i].fv));
            check($sformatf("v%0d.locked", i), 32'(bus.pl_locked), 32'(vecs[i].lk));
            check($sformatf("v%0d.owner", i), 32'(bus.pl_owner), 32'(vecs[i].own));
            check($sformatf("v%0d.err", i), 32'(bus.err_proto), 32'(vecs[i].err));
            @(posedge clk);
        end

        // Reset in the middle of a packet on PL0.
        #1 drive(4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        $display("mid-packet head gnt=%b fv=%b", bus.gnt, bus.flits_valid);
        check("mp.head.gnt", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #1 drive(4'b0001, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        $display("mid-packet body gnt=%b locked=%b", bus.gnt, bus.pl_locked);
        check("mp.body.locked", 32'(bus.pl_locked), 32'h1);
        check("mp.body.gnt", 32'(bus.gnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset gnt=%b fv=%b locked=%b err=%b", bus.gnt, bus.flits_valid,
                 bus.pl_locked, bus.err_proto);
        check("ar.gnt", 32'(bus.gnt), 32'h0);
        check("ar.fv", 32'(bus.flits_valid), 32'h0);
        check("ar.locked", 32'(bus.pl_locked), 32'h0);
        check("ar.err", 32'(bus.err_proto), 32'h0);
        @(posedge clk);
        #1 check("ar.hold.gnt", 32'(bus.gnt), 32'h0);
        drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        #1 drive(4'b0011, 8'h00, 4'b0011, 4'b0011, 4'b0000);
        @(negedge clk);
        $display("post-reset heads gnt=%b fv=%b", bus.gnt, bus.flits_valid);
        check("pr.gnt", 32'(bus.gnt), 32'h1);
        check("pr.fv", 32'(bus.flits_valid), 32'h1);
        @(posedge clk);

        // Owner of a locked PL re-sending a head is refused and flagged.
        #1 drive(4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        check("oh.lock.gnt", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #1 drive(4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        $display("owner head gnt=%b locked=%b err=%b", bus.gnt, bus.pl_locked, bus.err_proto);
        check("oh.gnt", 32'(bus.gnt), 32'h0);
        check("oh.fv", 32'(bus.flits_valid), 32'h0);
        check("oh.locked", 32'(bus.pl_locked), 32'h1);
        check("oh.err.before", 32'(bus.err_proto), 32'h0);
        @(posedge clk);
        #1 drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        $display("owner head aftermath err=%b", bus.err_proto);
        check("oh.err.after", 32'(bus.err_proto), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
